fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the core's decode stage and `instr_mem`. Owns the program counter and drives `instr_mem`'s `rd_en`/`addr`. Captures returned words into a 2-entry prefetch queue and presents them to decode with a valid/ready handshake, tagged with their PC. Handles branch redirect with squash, and a halt/resume sequence.

---
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues instr_mem reads, and buffers
// returned words in a 2-entry queue presented to decode with valid/ready.
module fetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] q_pc    [2];
  logic [DATA_W-1:0] q_instr [2];
  logic              head;
  logic [1:0]        count;
  logic              pop;
  logic              push;
  logic              wr_idx;
  logic [2:0]        occ;

  // Slots already committed after this cycle's pop; a read is only issued
  // when a free slot is guaranteed, so the queue can never overflow.
  assign pop    = out_valid & out_ready;
  assign occ    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign push   = inflight & ~redirect;
  assign wr_idx = head ^ count[0];

  assign mem_rd_en = ~rst & (state == RUN) & ~redirect & ~halt & (occ < 3'd2);
  assign mem_addr  = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = q_pc[head];
  assign out_instr = q_instr[head];
  assign halted    = (state == HALTED);

  always_comb begin
    state_nxt = state;
    if (halt) begin
      state_nxt = HALTED;
    end else if (redirect) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= mem_rd_en;
      if (redirect) begin
        pc    <= redirect_pc;
        count <= 2'd0;
      end else begin
        if (mem_rd_en) begin
          pc <= pc + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 2'd1;
        end else if (!push && pop) begin
          count <= count - 2'd1;
        end
        if (pop) begin
          head <= ~head;
        end
      end
    end
  end

  // Request stage (inflight_pc) and queue payload: data only, no reset needed
  always_ff @(posedge clk) begin
    if (mem_rd_en) begin
      inflight_pc <= pc;
    end
    if (push) begin
      q_pc[wr_idx]    <= inflight_pc;
      q_instr[wr_idx] <= mem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: expected instruction stream queued from stimulus,
// compared by a negedge monitor on every accepted handshake.
module tb_fetch_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          out_ready, redirect, halt;
  logic [AW-1:0] redirect_pc;
  logic          mem_rd_en, out_valid, halted;
  logic [AW-1:0] mem_addr, out_pc;
  logic [DW-1:0] mem_instr, out_instr;

  logic          mem_rd_en2, out_valid2, halted2;
  logic [AW-1:0] mem_addr2, out_pc2;
  logic [DW-1:0] mem_instr2, out_instr2;
  logic          redirect2 = 1'b0;
  logic          halt2 = 1'b0;
  logic [AW-1:0] redirect_pc2 = '0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  entry_t        exp_q[$];
  logic [AW-1:0] next_push_pc;
  logic [AW-1:0] last_pc = '0;
  logic [AW-1:0] exp2 = 10'h3FE;
  int            checks = 0;
  int            errors = 0;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'h000)) dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_instr(mem_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'h3FE)) dut_wrap (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2),
    .mem_instr(mem_instr2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .halt(halt2), .halted(halted2)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 16'hA000 + {{(DW-AW){1'b0}}, a};
  endfunction

  // Synchronous instruction memory: word for a read is present one cycle later
  always @(posedge clk) begin
    if (mem_rd_en)  mem_instr  <= word_at(mem_addr);
    if (mem_rd_en2) mem_instr2 <= word_at(mem_addr2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp();
    entry_t e;
    e.pc    = next_push_pc;
    e.instr = word_at(next_push_pc);
    exp_q.push_back(e);
    next_push_pc = next_push_pc + 1'b1;
  endtask

  task automatic set_stream(input logic [AW-1:0] start);
    exp_q.delete();
    next_push_pc = start;
    repeat (16) push_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (exp_q.size() < 16) push_exp();
  endtask

  task automatic do_reset(input logic [AW-1:0] start);
    rst = 1'b1;
    redirect = 1'b0;
    halt = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    set_stream(start);
    rst = 1'b0;
    #1;
  endtask

  // Monitor for the main instance
  initial begin
    logic          prev_hold;
    logic [AW-1:0] prev_pc;
    logic [DW-1:0] prev_instr;
    entry_t        e;
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_pc", 32'(out_pc), 32'(prev_pc));
          chk("hold_instr", 32'(out_instr), 32'(prev_instr));
        end
        if (halted) chk("halted_no_read", 32'(mem_rd_en), 32'd0);
        if (out_valid && out_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected actual=%0h expected=none", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", 32'(out_pc), 32'(e.pc));
            chk("out_instr", 32'(out_instr), 32'(e.instr));
            last_pc = out_pc;
          end
        end
        prev_hold  = out_valid && !out_ready && !redirect;
        prev_pc    = out_pc;
        prev_instr = out_instr;
      end
    end
  end

  // Monitor for the wrap instance: stream is 3FE, 3FF, 000, 001, ...
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp2 = 10'h3FE;
      end else if (out_valid2 && out_ready) begin
        chk("wrap_pc", 32'(out_pc2), 32'(exp2));
        chk("wrap_instr", 32'(out_instr2), 32'(word_at(exp2)));
        exp2 = exp2 + 1'b1;
      end
    end
  end

  initial begin
    int r;
    out_ready = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    redirect_pc = '0;

    // First-fetch latency and back-to-back delivery
    out_ready = 1'b1;
    do_reset(10'h000);
    chk("c0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("c1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("c2_valid", 32'(out_valid), 32'd1);
    chk("c2_pc", 32'(out_pc), 32'd0);
    repeat (10) begin
      tick();
      chk("no_bubble", 32'(out_valid), 32'd1);
    end

    // Backpressure after the first valid
    out_ready = 1'b0;
    do_reset(10'h000);
    tick();
    tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_rd_en", 32'(mem_rd_en), 32'd0);
    repeat (4) begin
      tick();
      chk("bp_rd_en", 32'(mem_rd_en), 32'd0);
      chk("bp_addr", 32'(mem_addr), 32'd2);
    end
    chk("bp_head_pc", 32'(out_pc), 32'd0);
    chk("bp_head_instr", 32'(out_instr), 32'hA000);
    tick();
    out_ready = 1'b1;
    repeat (6) tick();

    // Redirect from a full queue
    out_ready = 1'b0;
    repeat (3) tick();
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_rd_en", 32'(mem_rd_en), 32'd0);
    redirect = 1'b1;
    redirect_pc = 10'h200;
    set_stream(10'h200);
    #1;
    chk("redir_rd_en", 32'(mem_rd_en), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_n1_valid", 32'(out_valid), 32'd0);
    chk("redir_n1_rd_en", 32'(mem_rd_en), 32'd1);
    chk("redir_n1_addr", 32'(mem_addr), 32'h200);
    out_ready = 1'b1;
    repeat (8) tick();

    // Halt at pc 5, drain, resume by redirect
    do_reset(10'h000);
    for (int i = 0; i < 20 && mem_addr != 10'd5; i++) tick();
    chk("halt_reach", 32'(mem_addr), 32'd5);
    halt = 1'b1;
    #1;
    chk("halt_rd_en", 32'(mem_rd_en), 32'd0);
    tick();
    halt = 1'b0;
    #1;
    chk("halted_set", 32'(halted), 32'd1);
    repeat (6) begin
      tick();
      chk("halt_rd_en", 32'(mem_rd_en), 32'd0);
    end
    chk("halt_drained", 32'(out_valid), 32'd0);
    chk("halt_last_pc", 32'(last_pc), 32'd4);
    chk("halt_pc_hold", 32'(mem_addr), 32'd5);
    redirect = 1'b1;
    redirect_pc = 10'h005;
    set_stream(10'h005);
    tick();
    redirect = 1'b0;
    #1;
    chk("resume_halted", 32'(halted), 32'd0);
    repeat (8) tick();

    // Halt and redirect together
    halt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 10'h040;
    set_stream(10'h040);
    tick();
    halt = 1'b0;
    redirect = 1'b0;
    #1;
    chk("hr_halted", 32'(halted), 32'd1);
    chk("hr_valid", 32'(out_valid), 32'd0);
    chk("hr_addr", 32'(mem_addr), 32'h040);
    chk("hr_rd_en", 32'(mem_rd_en), 32'd0);
    repeat (4) begin
      tick();
      chk("hr_idle_valid", 32'(out_valid), 32'd0);
    end
    redirect = 1'b1;
    redirect_pc = 10'h040;
    set_stream(10'h040);
    tick();
    redirect = 1'b0;
    #1;
    chk("hr_restart_halted", 32'(halted), 32'd0);
    chk("hr_restart_addr", 32'(mem_addr), 32'h040);
    chk("hr_restart_rd_en", 32'(mem_rd_en), 32'd1);
    repeat (8) tick();

    // Asynchronous reset mid-cycle
    tick();
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);

    // Randomized traffic
    do_reset(10'h000);
    repeat (1500) begin
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 2 || (halted && r < 12)) begin
        redirect = 1'b1;
        redirect_pc = AW'($urandom_range(0, 1023));
        if (r == 0) halt = 1'b1;
        set_stream(redirect_pc);
      end else if (r < 4) begin
        halt = 1'b1;
      end
      tick();
      redirect = 1'b0;
      halt = 1'b0;
    end
    out_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
